// File: rtl/fetch_unit.sv
// SEQ core instruction-fetch front end: PC, fetch queue, decode handshake.
// Optional macro FETCH_MISALIGN_CHECK_EN: halt fetch on misaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_pc,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic [$clog2(DEPTH):0]     fetch_count,
  output logic                       misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   pcm_q [DEPTH];
  logic [31:0]   insm_q [DEPTH];

  logic          enq;
  logic          deq;
  logic          halt;
  logic          bad_tgt;
  logic [31:0]   tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_tgt = |redirect_pc[1:0];
  assign halt    = err_q;
  assign tgt     = redirect_pc;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign bad_tgt    = 1'b0;
  assign halt       = 1'b0;
  assign tgt        = {redirect_pc[31:2], 2'b00};
`endif

  assign id_valid = (cnt_q != '0) & ~redirect_valid;
  assign deq      = id_valid & id_ready;
  assign enq      = ~redirect_valid & ~halt
                  & ((cnt_q < FULL) | deq);

  assign imem_pc      = pc_q;
  assign fetch_count  = cnt_q;
  assign misalign_err = err_q;
  assign id_pc        = id_valid ? pcm_q[rd_q]  : 32'h0;
  assign id_instr     = id_valid ? insm_q[rd_q] : NOP;

  // Next-state: redirect flushes and reloads; otherwise enq/deq bookkeeping.
  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (redirect_valid) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (bad_tgt) err_d = 1'b1;
      else         pc_d  = tgt;
    end else begin
      if (enq) begin
        wr_d = wr_q + 1'b1;
        pc_d = pc_q + 32'd4;
      end
      if (deq) rd_d = rd_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Queue storage: capture {pc, instr} at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcm_q[i]  <= 32'h0;
        insm_q[i] <= NOP;
      end
    end else if (enq) begin
      pcm_q[wr_q]  <= pc_q;
      insm_q[wr_q] <= imem_instr;
    end
  end

endmodule
